// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer of the 16-bit RISC core.
// State codes are visible on O_state for debug and must not be renumbered.
package cpu_ctrl_pkg;

  localparam int unsigned PC_W_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_REGRD  = 3'd3,
    ST_ALU    = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // Stages that own the memory port; the only ones in which I_mem_ack matters.
  function automatic logic uses_mem_port(state_e st);
    return (st == ST_FETCH) || (st == ST_MEM);
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Memory request/acknowledge bus between the sequencer (master) and the memory port (slave).
interface cpu_ctrl_seq_if
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) ();

  logic            O_mem_req;
  logic            O_mem_we;
  logic [PC_W-1:0] O_mem_addr;
  logic            I_mem_ack;

  modport master (
    output O_mem_req,
    output O_mem_we,
    output O_mem_addr,
    input  I_mem_ack
  );

  modport slave (
    input  O_mem_req,
    input  O_mem_we,
    input  O_mem_addr,
    output I_mem_ack
  );

endinterface

// File: rtl/cpu_ctrl_pc.sv
// Program counter: word-addressed +1 increment or branch target, applied on the update strobe.
module cpu_ctrl_pc
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd,
  input  logic            br_q,
  input  logic [PC_W-1:0] res_q,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    // NOTE: hold value assigned first so every path writes pc_d; a missing branch would infer a latch.
    pc_d = pc_q;
    if (upd) begin
      pc_d = br_q ? res_q : pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: FETCH, DECODE, REGREAD, ALU, optional MEM, WB; one instruction at a time.
// Optional retired-instruction counter on O_retired when CPU_CTRL_RETIRE_CNT_EN is defined.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  cpu_ctrl_seq_if.master  mem,
  input  logic            I_dec_memop,
  input  logic            I_dec_store,
  input  logic            I_dec_regwr,
  input  logic            I_alu_branch,
  input  logic [PC_W-1:0] I_alu_result,
  input  logic            I_halt_req,
  output logic [PC_W-1:0] O_pc,
  output logic            O_en_fetch,
  output logic            O_en_decode,
  output logic            O_en_regrd,
  output logic            O_en_alu,
  output logic            O_en_regwr,
  output logic            O_halted,
  output logic [2:0]      O_state
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]     O_retired
`endif
);

  state_e          state_q, state_d;
  logic            br_q, br_d;
  logic [PC_W-1:0] res_q, res_d;
  logic            mem_ack;
  logic            wb_exit;

  // Ack is only meaningful while this sequencer owns the memory port.
  assign mem_ack = mem.I_mem_ack && uses_mem_port(state_q);
  assign wb_exit = (state_q == ST_WB);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_REGRD;
      ST_REGRD:  state_d = ST_ALU;
      ST_ALU:    state_d = I_dec_memop ? ST_MEM : ST_WB;
      ST_MEM:    if (mem_ack) state_d = ST_WB;
      ST_WB:     state_d = I_halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   if (!I_halt_req) state_d = ST_FETCH;
      default:   state_d = ST_RST;
    endcase
  end

  // The ALU resolves on the falling edge inside ALU, so its outputs are captured on the exit edge.
  always_comb begin
    br_d  = br_q;
    res_d = res_q;
    if (state_q == ST_ALU) begin
      br_d  = I_alu_branch;
      res_d = I_alu_result;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_RST;
      br_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      res_q   <= res_d;
    end
  end

  cpu_ctrl_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .upd   (wb_exit),
    .br_q  (br_q),
    .res_q (res_q),
    .pc    (O_pc)
  );

  // Moore decode from state_q; only the fetch load strobe also qualifies on the ack.
  always_comb begin
    mem.O_mem_req  = 1'b0;
    mem.O_mem_we   = 1'b0;
    mem.O_mem_addr = '0;
    O_en_fetch     = 1'b0;
    O_en_decode    = 1'b0;
    O_en_regrd     = 1'b0;
    O_en_alu       = 1'b0;
    O_en_regwr     = 1'b0;
    O_halted       = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem.O_mem_req  = 1'b1;
        mem.O_mem_addr = O_pc;
        O_en_fetch     = mem_ack;
      end
      ST_DECODE: O_en_decode = 1'b1;
      ST_REGRD:  O_en_regrd  = 1'b1;
      ST_ALU:    O_en_alu    = 1'b1;
      ST_MEM: begin
        mem.O_mem_req  = 1'b1;
        mem.O_mem_we   = I_dec_store;
        mem.O_mem_addr = res_q;
      end
      ST_WB:     O_en_regwr  = I_dec_regwr;
      ST_HALT:   O_halted    = 1'b1;
      default:   ;
    endcase
  end

  assign O_state = state_q;

`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (wb_exit) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign O_retired = retired_q;
`endif

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 16-bit RISC core.
- Steps each instruction through FETCH, DECODE, REGREAD, ALU, optional MEM and WB.
- Drives the per-stage enables of the decoder, register file, ALU and memory port, owns the program counter, and applies ALU branch decisions.
- Runs one instruction at a time with no overlap between instructions.

Parameters:
- PC_W, 16, width of program counter and memory address.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- I_clk  in  1  core clock; all state updates on rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_mem_ack  in  1  memory transfer complete for the current O_mem_req.
- I_dec_memop  in  1  decoded instruction needs a MEM stage (load/store).
- I_dec_store  in  1  MEM stage is a write; ignored when I_dec_memop=0.
- I_dec_regwr  in  1  decoded instruction writes a register.
- I_alu_branch  in  1  ALU branch decision (ALU O_shldBranch).
- I_alu_result  in  PC_W  ALU result: branch target or memory address.
- I_halt_req  in  1  request to stop at the next instruction boundary.
- O_pc  out  PC_W  current program counter.
- O_mem_req  out  1  memory request, held until acknowledged.
- O_mem_we  out  1  write qualifier for O_mem_req.
- O_mem_addr  out  PC_W  O_pc in FETCH; latched ALU result in MEM.
- O_en_fetch  out  1  instruction register load enable.
- O_en_decode  out  1  decoder enable.
- O_en_regrd  out  1  register file read enable.
- O_en_alu  out  1  ALU I_en.
- O_en_regwr  out  1  register file write strobe.
- O_halted  out  1  sequencer parked in HALT.
- O_state  out  3  current state code, for debug.

Behaviour:
- Reset: asynchronous, active-low. While I_rst_n=0 the state is RST, O_pc=RESET_PC, all other outputs are 0, and the branch/address latches are cleared. Reset asserted mid-instruction aborts it immediately; no writeback occurs.
- Output timing: all enables and memory outputs are Moore-decoded from the state register, so they are valid in the same cycle the state is entered.
- State codes (3 bits): RST=0, FETCH=1, DECODE=2, REGRD=3, ALU=4, MEM=5, WB=6, HALT=7.
- RST: advances to FETCH on the first clock edge after reset release.
- FETCH:
  - O_mem_req=1, O_mem_we=0, O_mem_addr=O_pc.
  - Stays in FETCH until I_mem_ack=1 is sampled on a rising edge. On that edge O_en_fetch=1 (same cycle) and the next state is DECODE.
  - An ack in the first FETCH cycle is legal (zero-wait memory).
- DECODE: O_en_decode=1 for one cycle, then REGRD.
- REGRD: O_en_regrd=1 for one cycle, then ALU.
- ALU:
  - O_en_alu=1 for one cycle. The ALU evaluates on the falling edge inside this cycle.
  - On the rising edge leaving ALU, latch I_alu_branch into br_q and I_alu_result into res_q.
  - Next state is MEM if I_dec_memop=1, else WB.
- MEM:
  - O_mem_req=1, O_mem_we=I_dec_store, O_mem_addr=res_q.
  - Stays in MEM until I_mem_ack=1, then goes to WB.
  - Address and we are held stable while waiting.
- WB:
  - O_en_regwr=I_dec_regwr for one cycle.
  - PC update on exit: if br_q, O_pc<=res_q; else O_pc<=O_pc+1 (word addressed, wraps 16'hFFFF to 16'h0000).
  - Next state is HALT if I_halt_req=1, else FETCH.
- HALT: O_halted=1, no enables active. Returns to FETCH on the first edge that samples I_halt_req=0.
- I_halt_req is sampled only in WB and HALT. A request raised mid-instruction lets the instruction complete.
- I_mem_ack outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - Non-memory instruction: 5 cycles (FETCH..WB).
  - Memory instruction: 6 cycles.
  - Each extra wait cycle on ack adds one cycle.
- Branch in a memory instruction: branch still taken from res_q in WB. The decoder guarantees this combination does not occur.

Optional Feature:
- Macro: CPU_CTRL_RETIRE_CNT_EN.
- Defined: adds output port O_retired (16 bits), reset to 0. It increments by 1 on every WB exit, wraps at 16'hFFFF, and holds in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg: state enum with the codes above, PC_W default, RESET_PC default.
- Sub-module cpu_ctrl_pc holds the PC register, the +1 increment and the branch mux. Inputs: clock, reset, update strobe, br_q, res_q.
- The FSM and latches stay in cpu_ctrl_seq.

Test Plan:
- Reset then release, ack held 1, ADD decoded (memop=0, regwr=1, branch=0) -> states 1,2,3,4,6 across 5 cycles; O_en_regwr pulses once; O_pc 0000->0001.
- Load with ack delayed 3 cycles in FETCH and 2 in MEM, I_alu_result=16'h0040 -> 11 cycles total; O_mem_addr=0040 and O_mem_we=0 held throughout MEM.
- Jump with I_alu_branch=1, I_alu_result=16'h1234 in ALU -> O_pc=1234 after WB; next FETCH has O_mem_addr=1234.
- O_pc=16'hFFFF, no branch -> O_pc wraps to 0000 after WB.
- I_halt_req raised during DECODE -> instruction completes and HALT is entered (O_halted=1); drop req -> FETCH on the next edge.
- I_rst_n pulled low mid-MEM -> outputs 0 and O_pc=RESET_PC immediately, without waiting for a clock. With CPU_CTRL_RETIRE_CNT_EN defined, O_retired=3 after three retired instructions.
